// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack, instruction register with pre-split fields.
// Optional request timeout fault enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [3:0]  opcode,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [2:0]  rc,
  output logic        comp,
  output logic [1:0]  cz,
  output logic [5:0]  imm6,
  output logic [8:0]  imm9
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_err
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic        cap_word;
  logic        cap_fault;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cap_word  = 1'b0;
    cap_fault = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (mem_ack) begin
          state_nxt = HOLD;
          pc_nxt    = pc + 16'd1;
          cap_word  = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = HOLD;
          cap_fault = 1'b1;
        end
`endif
      end
      HOLD: if (instr_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    // A redirect overrides everything, including a word returning this cycle.
    if (pc_load) begin
      state_nxt = REQ;
      pc_nxt    = pc_target;
      cap_word  = 1'b0;
      cap_fault = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= 16'h0000;
      instr_pc <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (cap_word) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
      end else if (cap_fault) begin
        instr    <= 16'h0000;
        instr_pc <= pc;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == REQ && !mem_ack && !pc_load && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (cap_fault)
        fetch_err <= 1'b1;
    end
  end
`endif

  assign mem_req     = (state == REQ);
  assign instr_valid = (state == HOLD);
  assign mem_addr    = pc;

  assign opcode = instr[15:12];
  assign ra     = instr[11:9];
  assign rb     = instr[8:6];
  assign rc     = instr[5:3];
  assign comp   = instr[2];
  assign cz     = instr[1:0];
  assign imm6   = instr[5:0];
  assign imm9   = instr[8:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: field table, memory model with scoreboard, redirect/stall/timeout sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr, mem_rdata;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        instr_valid, instr_ready;
  logic [15:0] instr, instr_pc;
  logic [3:0]  opcode;
  logic [2:0]  ra, rb, rc;
  logic        comp;
  logic [1:0]  cz;
  logic [5:0]  imm6;
  logic [8:0]  imm9;

  logic        mem_req_b, instr_valid_b;
  logic [15:0] mem_addr_b, instr_b, instr_pc_b;
  logic [3:0]  opcode_b;
  logic [2:0]  ra_b, rb_b, rc_b;
  logic        comp_b;
  logic [1:0]  cz_b;
  logic [5:0]  imm6_b;
  logic [8:0]  imm9_b;
`ifdef FETCH_TIMEOUT_EN
  logic        fetch_err, fetch_err_b;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(16'h0000)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_target(pc_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .comp(comp), .cz(cz), .imm6(imm6), .imm9(imm9)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err)
`endif
  );

  // Second instance starting at the top of the address space, zero-wait memory.
  instr_fetch_unit #(
    .RESET_PC(16'hFFFF)
`ifdef FETCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut_b (
    .clk(clk), .reset(reset), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_ack(mem_req_b), .mem_rdata(16'h1234), .pc_load(1'b0), .pc_target(16'h0000),
    .instr_valid(instr_valid_b), .instr_ready(1'b1), .instr(instr_b), .instr_pc(instr_pc_b),
    .opcode(opcode_b), .ra(ra_b), .rb(rb_b), .rc(rc_b), .comp(comp_b), .cz(cz_b),
    .imm6(imm6_b), .imm9(imm9_b)
`ifdef FETCH_TIMEOUT_EN
    , .fetch_err(fetch_err_b)
`endif
  );

  typedef struct {
    logic [15:0] word;
    logic [3:0]  opcode;
    logic [2:0]  ra, rb, rc;
    logic        comp;
    logic [1:0]  cz;
    logic [5:0]  imm6;
    logic [8:0]  imm9;
  } vec_t;

  vec_t        vecs[4];
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 0;
  int          wcnt = 0;
  bit          ack_en = 1'b1;
  bit          sb_en = 1'b1;
  bit          presented = 1'b0;
  logic [31:0] sb_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd4) return vecs[a[1:0]].word;
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'h0);
    chk("async_rst_req", 32'(mem_req), 32'h0);
    step();
    reset = 1'b1;
  endtask

  // Memory model: answers after ack_delay wait cycles and records what the DUT should latch.
  always @(negedge clk) begin
    if (reset && mem_req && ack_en) begin
      if (wcnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt      = 0;
        if (!pc_load) sb_q.push_back({mem_rdata, mem_addr});
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  // Each newly presented instruction must match the oldest accepted memory response.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!instr_valid) presented = 1'b0;
    else if (!presented && sb_en) begin
      presented = 1'b1;
      if (sb_q.size() == 0) chk("sb_empty", 32'({instr, instr_pc}), 32'hFFFF_FFFF);
      else begin
        exp = sb_q.pop_front();
        chk("sb_instr", 32'(instr), 32'(exp[31:16]));
        chk("sb_instr_pc", 32'(instr_pc), 32'(exp[15:0]));
      end
    end
  end

  initial begin
    vecs[0] = '{16'h22A0, 4'h2, 3'd1, 3'd2, 3'd4, 1'b0, 2'd0, 6'h20, 9'h0A0};
    vecs[1] = '{16'h2848, 4'h2, 3'd4, 3'd1, 3'd1, 1'b0, 2'd0, 6'h08, 9'h048};
    vecs[2] = '{16'h5ACE, 4'h5, 3'd5, 3'd3, 3'd1, 1'b1, 2'd2, 6'h0E, 9'h0CE};
    vecs[3] = '{16'hF1FF, 4'hF, 3'd0, 3'd7, 3'd7, 1'b1, 2'd3, 6'h3F, 9'h1FF};
    reset = 1'b0; pc_load = 1'b0; pc_target = 16'h0000; instr_ready = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    repeat (2) step();

    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_instr_pc", 32'(instr_pc), 32'h0);
    chk("rst_fields", 32'({opcode, ra, rb, rc, imm9}), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_addr_b", 32'(mem_addr_b), 32'hFFFF);
`ifdef FETCH_TIMEOUT_EN
    chk("rst_err", 32'(fetch_err), 32'h0);
`endif

    // Zero-wait stream: REQ then HOLD per instruction.
    instr_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tbl_req", 32'(mem_req), 32'h1);
      chk("tbl_addr", 32'(mem_addr), 32'(i));
      chk("tbl_valid_lo", 32'(instr_valid), 32'h0);
      if (i == 0) chk("wrap_addr_b", 32'(mem_addr_b), 32'hFFFF);
      if (i == 1) chk("wrap_next_addr_b", 32'(mem_addr_b), 32'h0000);
      step();
      chk("tbl_valid", 32'(instr_valid), 32'h1);
      chk("tbl_instr", 32'(instr), 32'(vecs[i].word));
      chk("tbl_instr_pc", 32'(instr_pc), 32'(i));
      chk("tbl_opcode", 32'(opcode), 32'(vecs[i].opcode));
      chk("tbl_ra", 32'(ra), 32'(vecs[i].ra));
      chk("tbl_rb", 32'(rb), 32'(vecs[i].rb));
      chk("tbl_rc", 32'(rc), 32'(vecs[i].rc));
      chk("tbl_comp", 32'(comp), 32'(vecs[i].comp));
      chk("tbl_cz", 32'(cz), 32'(vecs[i].cz));
      chk("tbl_imm6", 32'(imm6), 32'(vecs[i].imm6));
      chk("tbl_imm9", 32'(imm9), 32'(vecs[i].imm9));
      if (i == 0) begin
        chk("wrap_instr_pc_b", 32'(instr_pc_b), 32'hFFFF);
        chk("wrap_instr_b", 32'(instr_b), 32'h1234);
      end
    end

    // Memory answers after three wait cycles; request must stay stable.
    do_reset();
    ack_delay = 3;
    instr_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("wait_req", 32'(mem_req), 32'h1);
      chk("wait_addr", 32'(mem_addr), 32'h0);
      chk("wait_valid", 32'(instr_valid), 32'h0);
      step();
    end
    chk("wait_valid_hi", 32'(instr_valid), 32'h1);
    chk("wait_instr", 32'(instr), 32'h22A0);

    // Controller stalls for five cycles.
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_instr", 32'(instr), 32'h22A0);
      chk("stall_instr_pc", 32'(instr_pc), 32'h0);
      chk("stall_req", 32'(mem_req), 32'h0);
      chk("stall_pc", 32'(mem_addr), 32'h1);
    end

    // Redirect coinciding with an ack discards the returned word.
    ack_delay = 0;
    instr_ready = 1'b1;
    step();
    chk("redir_pre_addr", 32'(mem_addr), 32'h1);
    pc_load = 1'b1; pc_target = 16'h0040;
    step();
    pc_load = 1'b0;
    chk("redir_req", 32'(mem_req), 32'h1);
    chk("redir_addr", 32'(mem_addr), 32'h0040);
    chk("redir_instr", 32'(instr), 32'h22A0);
    chk("redir_valid", 32'(instr_valid), 32'h0);
    step();
    chk("redir_fetch", 32'(instr), 32'hA5E5);
    chk("redir_fetch_pc", 32'(instr_pc), 32'h0040);

    // Redirect in HOLD drops the held instruction even with instr_ready high.
    pc_load = 1'b1; pc_target = 16'h0080;
    step();
    pc_load = 1'b0;
    chk("hold_redir_valid", 32'(instr_valid), 32'h0);
    chk("hold_redir_req", 32'(mem_req), 32'h1);
    chk("hold_redir_addr", 32'(mem_addr), 32'h0080);
    step();
    chk("hold_redir_instr", 32'(instr), 32'hA525);
    chk("hold_redir_pc", 32'(instr_pc), 32'h0080);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: fault after eight REQ cycles, sticky until reset.
    do_reset();
    ack_en = 1'b0;
    sb_en = 1'b0;
    instr_ready = 1'b0;
    step();
    for (int k = 0; k < 7; k++) begin
      step();
      chk("tmo_err_lo", 32'(fetch_err), 32'h0);
      chk("tmo_valid_lo", 32'(instr_valid), 32'h0);
    end
    step();
    chk("tmo_err", 32'(fetch_err), 32'h1);
    chk("tmo_valid", 32'(instr_valid), 32'h1);
    chk("tmo_instr", 32'(instr), 32'h0);
    chk("tmo_instr_pc", 32'(instr_pc), 32'h0);
    instr_ready = 1'b1;
    step();
    chk("tmo_sticky", 32'(fetch_err), 32'h1);
    chk("tmo_req_again", 32'(mem_req), 32'h1);
    reset = 1'b0;
    #1;
    chk("tmo_err_cleared", 32'(fetch_err), 32'h0);
    step();
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
